// File: rtl/stream_upsizer_if.sv
// Boundary bundle of the stream upsizer: narrow input beats in, wide strobed words out.
// slave is the upsizer's view; master is the view of the producer/consumer around it.
interface stream_upsizer_if #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4
);
    localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;

    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [RATIO-1:0]     out_strb;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_strb, out_last, out_valid
    );

    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_data, out_strb, out_last, out_valid
    );
endinterface

// File: rtl/stream_upsizer.sv
// Gathers RATIO narrow beats (or fewer, closed early by in_last) into one wide word
// with a lane strobe and last flag; outputs come straight from registers.
module stream_upsizer #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4
) (
    input logic             clk_i,
    input logic             rst_i,
    stream_upsizer_if.slave bus
);
    localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int unsigned CntWidth  = $clog2(RATIO);
    localparam logic [CntWidth-1:0] LastLane = CntWidth'(RATIO - 1);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [OUT_WIDTH-1:0] buf_q, buf_d;
    logic [RATIO-1:0]     strb_q, strb_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic [CntWidth-1:0]  lane;
    logic                 in_hs;
    logic                 out_hs;

    // Combinational from out_ready so a released word can be refilled in the same cycle.
    assign bus.in_ready = !rst_i && ((state_q == FILL) || bus.out_ready);
    assign in_hs        = bus.in_valid && bus.in_ready;
    assign out_hs       = (state_q == HOLD) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        strb_d  = strb_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        lane    = cnt_q;

        if (out_hs) begin
            state_d = FILL;
            buf_d   = '0;
            strb_d  = '0;
            cnt_d   = '0;
            last_d  = 1'b0;
            lane    = '0;
        end

        if (in_hs) begin
            buf_d[lane*IN_WIDTH +: IN_WIDTH] = bus.in_data;
            strb_d[lane]                     = 1'b1;
            if ((lane == LastLane) || bus.in_last) begin
                state_d = HOLD;
                last_d  = bus.in_last;
                cnt_d   = '0;
            end else begin
                cnt_d = lane + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            buf_q   <= '0;
            strb_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            strb_q  <= strb_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign bus.out_data  = buf_q;
    assign bus.out_strb  = strb_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = (state_q == HOLD);
endmodule
